pow2_sum_normalizer: RTL and testbench

Upstream stage of the pseudo-softmax reciprocal path. It accumulates one vector of exponential terms (2^x values, unsigned fixed point) into a wide sum. It then normalizes the sum into a leading-one-stripped mantissa plus an exponent. The mantissa (fraction of 1.f) feeds the piecewise-linear reciprocal stage directly. The exponent goes to the downstream rescaling logic.

---
 rtl/pow2_sum_normalizer.sv | 202 ++++++++++++++++++++
 tb/tb_pow2_sum_normalizer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pow2_sum_normalizer.sv
// pow2_sum_normalizer
//   Accumulates one vector of unsigned exponential terms into a saturating
//   ACC_WIDTH-bit sum, then normalizes it by left shifting until the MSB is
//   set. The result is a leading-one-stripped mantissa plus exponent.
//
// Optional feature macro: SUM_ROUND_EN
//   Defined:   the mantissa is rounded to nearest, ties away from zero. One
//              extra NORM cycle is spent before OUT.
//   Undefined: the mantissa is truncated.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   term handshake; in_data term, in_last ends the vector
//   out_valid/out_ready result handshake
//   mant_out            fraction bits below the leading one, left-aligned
//   exp_out             floor(log2(sum)), 0 for a zero sum
//   zero_out            sum was zero
//   sat_out             accumulator saturated (or rounding overflowed)
module pow2_sum_normalizer #(
  parameter int IN_WIDTH   = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int MANT_WIDTH = 8,
  parameter int EXP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANT_WIDTH-1:0] mant_out,
  output logic [EXP_WIDTH-1:0]  exp_out,
  output logic                  zero_out,
  output logic                  sat_out
);

  localparam int FW = ACC_WIDTH - 1;  // bits below the leading one
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = EXP_WIDTH'(ACC_WIDTH - 1);

  typedef enum logic [1:0] {ACCUM, NORM, OUT} state_t;

  state_t                  state, state_nxt;
  logic [ACC_WIDTH-1:0]    acc;
  logic [EXP_WIDTH-1:0]    shamt;
  logic                    sat;
  logic [MANT_WIDTH-1:0]   mant_q;
  logic [EXP_WIDTH-1:0]    exp_q;
  logic                    zero_q, sat_q;

  logic [ACC_WIDTH:0]      sum_ext;
  logic [MANT_WIDTH-1:0]   mant_t;
  logic [EXP_WIDTH-1:0]    exp_t;
  logic                    acc_zero, acc_msb;

  // One extra bit of headroom catches overflow of the true sum.
  assign sum_ext  = {1'b0, acc} + (ACC_WIDTH+1)'(in_data);
  assign acc_zero = (acc == '0);
  assign acc_msb  = acc[ACC_WIDTH-1];
  assign exp_t    = EXP_MAX - shamt;

  // Mantissa: bits directly below the leading one, zero-padded when the
  // accumulator has fewer fraction bits than the mantissa.
  for (genvar i = 0; i < MANT_WIDTH; i++) begin : g_mant
    if (FW - 1 - i >= 0) begin : g_bit
      assign mant_t[MANT_WIDTH-1-i] = acc[FW-1-i];
    end else begin : g_pad
      assign mant_t[MANT_WIDTH-1-i] = 1'b0;
    end
  end

`ifdef SUM_ROUND_EN
  logic                  rnd;     // second NORM phase: rounding cycle
  logic                  rbit;    // first bit dropped below the mantissa
  logic [MANT_WIDTH:0]   mant_inc;

  if (FW - 1 - MANT_WIDTH >= 0) begin : g_rbit
    assign rbit = acc[FW-1-MANT_WIDTH];
  end else begin : g_norbit
    assign rbit = 1'b0;
  end

  assign mant_inc = {1'b0, mant_t} + (MANT_WIDTH+1)'(rbit);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (in_valid && in_last) state_nxt = NORM;
      NORM: begin
        if (acc_zero) state_nxt = OUT;
`ifdef SUM_ROUND_EN
        else if (acc_msb && rnd) state_nxt = OUT;
`else
        else if (acc_msb) state_nxt = OUT;
`endif
      end
      OUT:   if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Output decode from the state register only
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == OUT);
  end

  assign mant_out = mant_q;
  assign exp_out  = exp_q;
  assign zero_out = zero_q;
  assign sat_out  = sat_q;

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      shamt  <= '0;
      sat    <= 1'b0;
      mant_q <= '0;
      exp_q  <= '0;
      zero_q <= 1'b0;
      sat_q  <= 1'b0;
`ifdef SUM_ROUND_EN
      rnd    <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (sum_ext[ACC_WIDTH]) begin
              acc <= '1;
              sat <= 1'b1;
            end else begin
              acc <= sum_ext[ACC_WIDTH-1:0];
            end
          end
        end
        NORM: begin
          if (acc_zero) begin
            zero_q <= 1'b1;
            mant_q <= '0;
            exp_q  <= '0;
            sat_q  <= sat;
          end else if (!acc_msb) begin
            acc   <= acc << 1;
            shamt <= shamt + 1'b1;
          end else begin
`ifdef SUM_ROUND_EN
            if (!rnd) begin
              rnd <= 1'b1;
            end else if (mant_inc[MANT_WIDTH]) begin
              // Rounding carried into the leading one.
              if (exp_t == EXP_MAX) begin
                mant_q <= '1;
                exp_q  <= exp_t;
                sat_q  <= 1'b1;
              end else begin
                mant_q <= '0;
                exp_q  <= exp_t + 1'b1;
                sat_q  <= sat;
              end
            end else begin
              mant_q <= mant_inc[MANT_WIDTH-1:0];
              exp_q  <= exp_t;
              sat_q  <= sat;
            end
`else
            mant_q <= mant_t;
            exp_q  <= exp_t;
            sat_q  <= sat;
`endif
          end
        end
        OUT: begin
          if (out_ready) begin
            acc    <= '0;
            shamt  <= '0;
            sat    <= 1'b0;
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            sat_q  <= 1'b0;
`ifdef SUM_ROUND_EN
            rnd    <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pow2_sum_normalizer.sv
// Self-checking bench for pow2_sum_normalizer: reset state, a table of
// directed vectors, hand sequences for back-pressure and mid-NORM reset,
// saturation, and randomized vectors against a sum/log2 reference model.
module tb_pow2_sum_normalizer;
  localparam int IW = 8, AW = 16, MW = 8, EW = 4;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_last, out_ready;
  logic [IW-1:0] in_data;
  logic          in_ready, out_valid, zero_out, sat_out;
  logic [MW-1:0] mant_out;
  logic [EW-1:0] exp_out;

  pow2_sum_normalizer #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .MANT_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .exp_out(exp_out), .zero_out(zero_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] terms_q[$];

  typedef struct {
    int         n;
    logic [7:0] t[4];
    int         e, m, z, s, lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: clamped integer sum, floor(log2), fraction scaled to MW bits.
  task automatic model(output int e, output int m, output int z, output int s, output int lat);
    longint sum = 0;
    longint full;
    s = 0; z = 0; e = 0; m = 0;
    foreach (terms_q[i]) begin
      sum += terms_q[i];
      if (sum > (64'd1 << AW) - 1) begin
        sum = (64'd1 << AW) - 1;
        s = 1;
      end
    end
    if (sum == 0) begin
      z = 1;
      lat = 1;
    end else begin
      for (int b = 0; b < AW; b++) if ((sum >> b) & 1) e = b;
      full = ((sum - (64'd1 << e)) << (MW + 1)) >> e;
`ifdef SUM_ROUND_EN
      m = int'(full >> 1) + int'(full & 1);
      if (m == (1 << MW)) begin
        if (e == AW - 1) begin m = (1 << MW) - 1; s = 1; end
        else begin m = 0; e = e + 1; end
      end
      lat = AW - int'($clog2(sum + 1)) + 2;
      if (s == 1 && m == (1 << MW) - 1 && e == AW - 1) lat = 2;
`else
      m = int'(full >> 1);
      lat = AW - e;
`endif
    end
  endtask

  // Drives terms_q with random idle gaps; returns one step after the edge
  // that accepted the last term.
  task automatic send_terms(input int gap_max);
    foreach (terms_q[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = terms_q[i];
      in_last  = (i == terms_q.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for the result, checks latency and fields, optionally stalls
  // (driving a bogus term when poke is set), then retires it.
  task automatic get_result(input string name, input int e, input int m, input int z,
                            input int s, input int lat, input int stall, input bit poke);
    int k = 0;
    while (k < 200) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (out_valid) break;
    end
    check({name, " latency"}, k, lat);
    check({name, " exp"}, exp_out, e);
    check({name, " mant"}, mant_out, m);
    check({name, " zero"}, zero_out, z);
    check({name, " sat"}, sat_out, s);
    check({name, " in_ready"}, in_ready, 0);
    for (int c = 0; c < stall; c++) begin
      if (poke) begin
        in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
      end
      @(posedge clk); #1;
      check({name, " hold valid"}, out_valid, 1);
      check({name, " hold exp"}, exp_out, e);
      check({name, " hold mant"}, mant_out, m);
      check({name, " hold in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check({name, " retire out_valid"}, out_valid, 0);
    check({name, " retire in_ready"}, in_ready, 1);
  endtask

  vec_t tbl[7];

  initial begin
    int e, m, z, s, lat;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset mant", mant_out, 0);
    check("reset exp", exp_out, 0);
    check("reset zero", zero_out, 0);
    check("reset sat", sat_out, 0);

    // Directed table (truncating build).
    tbl[0] = '{3, '{8'h10, 8'h20, 8'h30, 8'h00}, 6, 'h80, 0, 0, 10};
    tbl[1] = '{1, '{8'h01, 8'h00, 8'h00, 8'h00}, 0, 'h00, 0, 0, 16};
    tbl[2] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 'h00, 1, 0, 1};
    tbl[3] = '{1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 7, 'hFE, 0, 0, 9};
    tbl[4] = '{2, '{8'h80, 8'h80, 8'h00, 8'h00}, 8, 'h00, 0, 0, 8};
    tbl[5] = '{4, '{8'h01, 8'h02, 8'h04, 8'h08}, 3, 'hE0, 0, 0, 13};
    tbl[6] = '{1, '{8'h03, 8'h00, 8'h00, 8'h00}, 1, 'h80, 0, 0, 15};
`ifndef SUM_ROUND_EN
    for (int i = 0; i < 7; i++) begin
      terms_q.delete();
      for (int j = 0; j < tbl[i].n; j++) terms_q.push_back(tbl[i].t[j]);
      send_terms(0);
      get_result($sformatf("tbl%0d", i), tbl[i].e, tbl[i].m, tbl[i].z, tbl[i].s, tbl[i].lat, 0, 1'b0);
    end
`endif

    // Saturation: 300 x 0xFF.
    terms_q.delete();
    repeat (300) terms_q.push_back(8'hFF);
    send_terms(0);
    model(e, m, z, s, lat);
    check("sat model flag", s, 1);
    get_result("saturate", e, m, z, s, lat, 0, 1'b0);

    // Back-pressure with in_valid asserted while holding the result.
    terms_q = '{8'h10, 8'h20, 8'h30};
    send_terms(0);
    model(e, m, z, s, lat);
    get_result("stall", e, m, z, s, lat, 5, 1'b1);
    terms_q = '{8'h40};
    send_terms(0);
    model(e, m, z, s, lat);
    get_result("after stall", e, m, z, s, lat, 0, 1'b0);

    // Reset in the middle of NORM discards the pending result.
    terms_q = '{8'h01};
    send_terms(0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("midnorm rst out_valid", out_valid, 0);
    check("midnorm rst in_ready", in_ready, 1);
    repeat (20) @(posedge clk);
    #1 check("midnorm rst stays idle", out_valid, 0);
    terms_q = '{8'h03};
    send_terms(0);
    model(e, m, z, s, lat);
    get_result("after rst", e, m, z, s, lat, 0, 1'b0);

    // Randomized vectors.
    for (int v = 0; v < 40; v++) begin
      int n;
      terms_q.delete();
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 8);
      for (int j = 0; j < n; j++)
        terms_q.push_back(IW'($urandom_range(0, 255) >> $urandom_range(0, 7)));
      send_terms(2);
      model(e, m, z, s, lat);
      get_result($sformatf("rand%0d", v), e, m, z, s, lat, $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
